// File: rtl/sdf_r2_stage2.sv
// sdf_r2_stage2: second radix-2 SDF DIF stage of the 32-point FFT.
// 8-deep feedback line, W16 twiddle with saturation, drain sequencer.
module sdf_r2_stage2 #(
   parameter int IW    = 14,
   parameter int OW    = 15,
   parameter int WW    = 8,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   input  logic [IW-1:0] data_in_r,
   input  logic [IW-1:0] data_in_i,
   output logic          valid_o,
   output logic [OW-1:0] data_out_r,
   output logic [OW-1:0] data_out_i,
   output logic          err_o
);

   localparam int CW = $clog2(2 * DEPTH);
   localparam int DW = OW + 1;
   localparam int PW = DW + WW + 1;
   localparam logic signed [PW-1:0] SMAX = PW'((1 << (OW - 1)) - 1);
   localparam logic signed [PW-1:0] SMIN = PW'(-(1 << (OW - 1)));

   typedef enum logic {
      S_RUN   = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic                 r_va;
   logic        [IW-1:0] r_ar;
   logic        [IW-1:0] r_ai;
   logic        [CW-1:0] r_cnt;
   logic                 r_pend;
   logic                 r_err;
   logic signed [OW-1:0] r_dlr [DEPTH];
   logic signed [OW-1:0] r_dli [DEPTH];

   logic                 w_adv;
   logic                 w_vo;
   logic                 w_pend_nxt;
   logic                 w_err_nxt;
   logic        [CW-1:0] w_cnt_nxt;
   logic signed [OW-1:0] w_dinr;
   logic signed [OW-1:0] w_dini;
   logic signed [OW-1:0] w_outr;
   logic signed [OW-1:0] w_outi;

   logic        [CW-2:0] w_k;
   logic signed [WW-1:0] w_wr;
   logic signed [WW-1:0] w_wi;
   logic signed [OW-1:0] w_ar;
   logic signed [OW-1:0] w_ai;
   logic signed [OW-1:0] w_br;
   logic signed [OW-1:0] w_bi;
   logic signed [OW-1:0] w_sumr;
   logic signed [OW-1:0] w_sumi;
   logic signed [DW-1:0] w_dr;
   logic signed [DW-1:0] w_di;
   logic signed [PW-1:0] w_drx;
   logic signed [PW-1:0] w_dix;
   logic signed [PW-1:0] w_wrx;
   logic signed [PW-1:0] w_wix;
   logic signed [PW-1:0] w_pr;
   logic signed [PW-1:0] w_pi;
   logic signed [PW-1:0] w_shr;
   logic signed [PW-1:0] w_shi;
   logic signed [OW-1:0] w_twr;
   logic signed [OW-1:0] w_twi;

   function automatic logic signed [OW-1:0] f_sat(
      input logic signed [PW-1:0] v
   );
      if (v > SMAX) begin
         f_sat = SMAX[OW-1:0];
      end else if (v < SMIN) begin
         f_sat = SMIN[OW-1:0];
      end else begin
         f_sat = v[OW-1:0];
      end
   endfunction

   assign w_k    = r_cnt[CW-2:0];
   assign w_ar   = {{(OW - IW){r_ar[IW-1]}}, r_ar};
   assign w_ai   = {{(OW - IW){r_ai[IW-1]}}, r_ai};
   assign w_br   = r_dlr[DEPTH-1];
   assign w_bi   = r_dli[DEPTH-1];
   assign w_sumr = w_br + w_ar;
   assign w_sumi = w_bi + w_ai;
   assign w_dr   = {w_br[OW-1], w_br} - {w_ar[OW-1], w_ar};
   assign w_di   = {w_bi[OW-1], w_bi} - {w_ai[OW-1], w_ai};
   assign w_drx  = {{(PW - DW){w_dr[DW-1]}}, w_dr};
   assign w_dix  = {{(PW - DW){w_di[DW-1]}}, w_di};
   assign w_wrx  = {{(PW - WW){w_wr[WW-1]}}, w_wr};
   assign w_wix  = {{(PW - WW){w_wi[WW-1]}}, w_wi};
   assign w_pr   = w_drx * w_wrx - w_dix * w_wix;
   assign w_pi   = w_drx * w_wix + w_dix * w_wrx;
   assign w_shr  = w_pr >>> 6;
   assign w_shi  = w_pi >>> 6;
   assign w_twr  = f_sat(w_shr);
   assign w_twi  = f_sat(w_shi);

   // W16^k in Q1.6
   always_comb begin
      w_wr = 8'sd64;
      w_wi = 8'sd0;
      unique case (w_k)
         3'd0: begin w_wr =  8'sd64; w_wi =  8'sd0;  end
         3'd1: begin w_wr =  8'sd59; w_wi = -8'sd24; end
         3'd2: begin w_wr =  8'sd45; w_wi = -8'sd45; end
         3'd3: begin w_wr =  8'sd24; w_wi = -8'sd59; end
         3'd4: begin w_wr =  8'sd0;  w_wi = -8'sd64; end
         3'd5: begin w_wr = -8'sd24; w_wi = -8'sd59; end
         3'd6: begin w_wr = -8'sd45; w_wi = -8'sd45; end
         3'd7: begin w_wr = -8'sd59; w_wi = -8'sd24; end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_adv       = 1'b0;
      w_vo        = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_err_nxt   = r_err;
      w_dinr      = '0;
      w_dini      = '0;
      w_outr      = w_br;
      w_outi      = w_bi;
      unique case (r_state)
         S_RUN: begin
            if (r_va) begin
               w_adv     = 1'b1;
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == '1) begin
                  w_pend_nxt = 1'b1;
               end
               if (!r_cnt[CW-1]) begin
                  w_dinr = w_ar;
                  w_dini = w_ai;
                  w_vo   = r_pend;
               end else begin
                  w_dinr = w_twr;
                  w_dini = w_twi;
                  w_outr = w_sumr;
                  w_outi = w_sumi;
                  w_vo   = 1'b1;
               end
            end else if (r_cnt == '0 && r_pend) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // flush stored differences; incoming samples are dropped
            w_adv     = 1'b1;
            w_vo      = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_va) begin
               w_err_nxt = 1'b1;
            end
            if (r_cnt == CW'(DEPTH - 1)) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
               w_pend_nxt  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_va       <= 1'b0;
         r_ar       <= '0;
         r_ai       <= '0;
         r_cnt      <= '0;
         r_pend     <= 1'b0;
         r_err      <= 1'b0;
         valid_o    <= 1'b0;
         data_out_r <= '0;
         data_out_i <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_dlr[i] <= '0;
            r_dli[i] <= '0;
         end
      end else begin
         r_va    <= valid_i;
         r_ar    <= data_in_r;
         r_ai    <= data_in_i;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
         r_err   <= w_err_nxt;
         valid_o <= w_vo;
         if (w_vo) begin
            data_out_r <= w_outr;
            data_out_i <= w_outi;
         end
         if (w_adv) begin
            r_dlr[0] <= w_dinr;
            r_dli[0] <= w_dini;
            for (int i = 1; i < DEPTH; i++) begin
               r_dlr[i] <= r_dlr[i-1];
               r_dli[i] <= r_dli[i-1];
            end
         end
      end
   end

   assign err_o = r_err;

endmodule

// File: tb/tb_sdf_r2_stage2.sv
// tb_sdf_r2_stage2: directed frames against a frame-level DIF model.
// Expected output stream: sums(f), then diffs(f) before sums(f+1).
module tb_sdf_r2_stage2;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [13:0] din_r;
   logic [13:0] din_i;
   logic        valid_o;
   logic [14:0] dout_r;
   logic [14:0] dout_i;
   logic        err_o;

   int ntest = 0;
   int nfail = 0;
   int cyc   = 0;
   int xr[16];
   int xi[16];
   int qr[$];
   int qi[$];
   int hr[8];
   int hi[8];
   bit held = 1'b0;
   int cap_r[$];
   int cap_i[$];
   int cap_t[$];

   const int WR[8] = '{64, 59, 45, 24, 0, -24, -45, -59};
   const int WI[8] = '{0, -24, -45, -59, -64, -59, -45, -24};

   sdf_r2_stage2 dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .data_in_r  (din_r),
      .data_in_i  (din_i),
      .valid_o    (valid_o),
      .data_out_r (dout_r),
      .data_out_i (dout_i),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat15(input int v);
      if (v > 16383) return 16383;
      if (v < -16384) return -16384;
      return v;
   endfunction

   function automatic int diff_re(input int k);
      int dr = xr[k] - xr[k+8];
      int di = xi[k] - xi[k+8];
      return sat15((dr * WR[k] - di * WI[k]) >>> 6);
   endfunction

   function automatic int diff_im(input int k);
      int dr = xr[k] - xr[k+8];
      int di = xi[k] - xi[k+8];
      return sat15((dr * WI[k] + di * WR[k]) >>> 6);
   endfunction

   task automatic model_frame();
      if (held) begin
         for (int k = 0; k < 8; k++) begin
            qr.push_back(hr[k]);
            qi.push_back(hi[k]);
         end
      end
      for (int k = 0; k < 8; k++) begin
         qr.push_back(xr[k] + xr[k+8]);
         qi.push_back(xi[k] + xi[k+8]);
         hr[k] = diff_re(k);
         hi[k] = diff_im(k);
      end
      held = 1'b1;
   endtask

   task automatic model_flush();
      if (held) begin
         for (int k = 0; k < 8; k++) begin
            qr.push_back(hr[k]);
            qi.push_back(hi[k]);
         end
      end
      held = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && valid_o) begin
         cap_r.push_back(int'($signed(dout_r)));
         cap_i.push_back(int'($signed(dout_i)));
         cap_t.push_back(cyc);
         if (qr.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            check("out_re", int'($signed(dout_r)), qr.pop_front());
            check("out_im", int'($signed(dout_i)), qi.pop_front());
         end
      end
   end

   task automatic clear_x();
      for (int n = 0; n < 16; n++) begin
         xr[n] = 0;
         xi[n] = 0;
      end
   endtask

   task automatic begin_test();
      cap_r.delete();
      cap_i.delete();
      cap_t.delete();
   endtask

   task automatic send_frame(input int stall_at, input int stall_len);
      model_frame();
      for (int i = 0; i < 16; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               @(posedge clk); #1;
               valid_i = 1'b0;
            end
         end
         @(posedge clk); #1;
         valid_i = 1'b1;
         din_r   = 14'(xr[i]);
         din_i   = 14'(xi[i]);
      end
   endtask

   task automatic end_stream();
      @(posedge clk); #1;
      valid_i = 1'b0;
      din_r   = '0;
      din_i   = '0;
      model_flush();
   endtask

   task automatic finish_test(input string name);
      repeat (25) @(posedge clk);
      #1;
      check(name, qr.size(), 0);
   endtask

   task automatic check_cap(input string name, input int idx,
                            input int er, input int ei);
      if (idx < cap_r.size()) begin
         check({name, "_re"}, cap_r[idx], er);
         check({name, "_im"}, cap_i[idx], ei);
      end else begin
         check({name, "_missing"}, cap_r.size(), idx + 1);
      end
   endtask

   initial begin
      rst     = 1'b1;
      valid_i = 1'b0;
      din_r   = '0;
      din_i   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_valid", int'(valid_o), 0);
      check("rst_re", int'(dout_r), 0);
      check("rst_im", int'(dout_i), 0);
      check("rst_err", int'(err_o), 0);

      // impulse
      begin_test();
      clear_x();
      xr[0] = 100;
      send_frame(-1, 0);
      end_stream();
      finish_test("imp_drained");
      check("imp_nvalid", cap_r.size(), 16);
      check_cap("imp_sum0", 0, 100, 0);
      check_cap("imp_dif0", 8, 100, 0);
      check("imp_err", int'(err_o), 0);

      // constant
      begin_test();
      for (int n = 0; n < 16; n++) begin
         xr[n] = 64;
         xi[n] = 0;
      end
      send_frame(-1, 0);
      end_stream();
      finish_test("const_drained");
      check_cap("const_sum3", 3, 128, 0);
      check_cap("const_dif5", 13, 0, 0);

      // twiddle k=1
      begin_test();
      clear_x();
      xr[1] = 64;
      check("pin_tw_re", diff_re(1), 59);
      check("pin_tw_im", diff_im(1), -24);
      send_frame(-1, 0);
      end_stream();
      finish_test("tw_drained");
      check_cap("tw_sum1", 1, 64, 0);
      check_cap("tw_dif1", 9, 59, -24);
      check_cap("tw_dif2", 10, 0, 0);

      // saturation
      begin_test();
      clear_x();
      xr[1] = 8191;
      xi[1] = 8191;
      xr[9] = -8192;
      xi[9] = -8192;
      check("pin_sat_re", diff_re(1), 16383);
      check("pin_sat_im", diff_im(1), 8959);
      send_frame(-1, 0);
      end_stream();
      finish_test("sat_drained");
      check_cap("sat_sum1", 1, -1, -1);
      check_cap("sat_dif1", 9, 16383, 8959);

      // stall in frame 0, frames back-to-back
      begin_test();
      for (int n = 0; n < 16; n++) begin
         xr[n] = n * 300 - 2000;
         xi[n] = 500 - n * 60;
      end
      send_frame(10, 3);
      for (int n = 0; n < 16; n++) begin
         xr[n] = (n * n * 37) % 4000 - 2000;
         xi[n] = (n % 2 == 1) ? 1000 : -1500;
      end
      send_frame(-1, 0);
      end_stream();
      finish_test("b2b_drained");
      check("b2b_nvalid", cap_t.size(), 32);
      if (cap_t.size() >= 24) begin
         check("b2b_holes", cap_t[23] - cap_t[0] + 1 - 24, 3);
      end

      // valid_i during DRAIN
      begin_test();
      for (int n = 0; n < 16; n++) begin
         xr[n] = n * 50;
         xi[n] = -n * 20;
      end
      send_frame(-1, 0);
      end_stream();
      @(posedge clk); #1;
      @(posedge clk); #1;
      valid_i = 1'b1;
      din_r   = 14'(1234);
      din_i   = 14'(-777);
      @(posedge clk); #1;
      valid_i = 1'b0;
      din_r   = '0;
      din_i   = '0;
      finish_test("err_drained");
      check("err_set", int'(err_o), 1);
      repeat (5) @(posedge clk);
      #1;
      check("err_sticky", int'(err_o), 1);

      // reset at sample 5, then a fresh frame
      begin_test();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         valid_i = 1'b1;
         din_r   = 14'(700 + i);
         din_i   = 14'(-300 - i);
      end
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("arst_valid", int'(valid_o), 0);
      check("arst_re", int'(dout_r), 0);
      check("arst_im", int'(dout_i), 0);
      check("arst_err", int'(err_o), 0);
      valid_i = 1'b0;
      qr.delete();
      qi.delete();
      held = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_x();
      xr[3] = -500;
      xi[3] = 200;
      send_frame(-1, 0);
      end_stream();
      finish_test("post_rst_drained");
      check("post_rst_nvalid", cap_r.size(), 16);
      check_cap("post_rst_sum3", 3, -500, 200);
      check_cap("post_rst_dif3", 11, -4, 535);
      check("post_rst_err", int'(err_o), 0);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
